offset_cal_ctrl: RTL
====================

OFFSET_CAL_CTRL -- requirements
Module: offset_cal_ctrl

Interface
REQ-001 Parameter N_LOG2, default 4, log2 of samples averaged per calibration (1..6).
REQ-002 Parameter SETTLE_CYC, default 8, clock cycles waited after input short before sampling (1..255).
REQ-003 Parameter TARGET, default 10'd512, ideal code for shorted input (unsigned 10-bit).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cal_start  input  1  request calibration; sampled only in IDLE.
REQ-007 cal_abort  input  1  abandon calibration in progress.
REQ-008 sample_valid  input  1  sample_data carries a new ADC conversion this cycle.
REQ-009 sample_data  input  10  unsigned raw ADC code.
REQ-010 mux_cal_en  output  1  shorts ADC input to calibration reference.
REQ-011 cal_busy  output  1  high in any state other than IDLE.
REQ-012 cal_done  output  1  one-cycle pulse when a new offset is loaded.
REQ-013 offset_out  output  10  two's-complement offset for the conditional offset stage, registered.
REQ-014 offset_valid  output  1  offset_out holds a completed calibration result.

Function
REQ-015 FSM states IDLE, SETTLE, ACCUM, COMPUTE, DONE; reset state IDLE.
REQ-016 IDLE -> SETTLE on cal_start=1; settle counter and accumulator cleared on this transition.
REQ-017 SETTLE lasts exactly SETTLE_CYC cycles; sample_valid ignored; then -> ACCUM.
REQ-018 ACCUM adds sample_data to accumulator on each cycle with sample_valid=1; after the 2^N_LOG2-th accepted sample -> COMPUTE.
REQ-019 Accumulator width 10+N_LOG2+1 bits; never overflows.
REQ-020 COMPUTE (one cycle): mean = accumulator >> N_LOG2 (rounding per REQ-031); diff = TARGET - mean as 11-bit signed.
REQ-021 diff saturated to [-512, +511] then loaded into offset_out on COMPUTE -> DONE edge; offset_valid set to 1.
REQ-022 DONE lasts one cycle with cal_done=1, then -> IDLE.
REQ-023 mux_cal_en=1 exactly in SETTLE and ACCUM.
REQ-024 cal_start while cal_busy=1 ignored; cal_start in DONE ignored.
REQ-025 cal_abort=1 in SETTLE or ACCUM -> IDLE next cycle; no cal_done; offset_out and offset_valid unchanged.
REQ-026 cal_abort in COMPUTE or DONE ignored; cal_abort and cal_start together in IDLE: abort wins, stay IDLE.
REQ-027 Latency: cal_start cycle 0 -> ACCUM at cycle SETTLE_CYC+1; cal_done two cycles after the final accepted sample.

Reset
REQ-028 rst_n=0 immediately forces IDLE, offset_out=10'd0, offset_valid=0, cal_done=0, cal_busy=0, mux_cal_en=0, counters and accumulator 0.
REQ-029 Reset mid-calibration discards partial accumulation; no cal_done emitted.

Configuration
REQ-030 Macro OFFSET_CAL_ROUND_EN selects mean rounding.
REQ-031 Defined: mean = (accumulator + 2^(N_LOG2-1)) >> N_LOG2 (round half up); undefined: mean = accumulator >> N_LOG2 (truncate).

Structure
REQ-032 Package adc_cal_pkg holds FSM state encoding, offset width (10) and default parameter values.
REQ-033 One sub-module cal_accum: clear, enable, sample input, sample counter, accumulator and count-reached flag.

Verification (N_LOG2=4, SETTLE_CYC=8, TARGET=512)
REQ-034 16 samples of 500 -> offset_out=10'h00C, offset_valid=1, single cal_done pulse, mux_cal_en high SETTLE+ACCUM only.
REQ-035 16 samples of 530 -> offset_out=10'h3EE (-18); 16 samples of 0 -> offset_out=10'h1FF (saturated +511).
REQ-036 8 samples of 500 then 8 of 501 (sum 8008) -> offset_out=10'h00B with OFFSET_CAL_ROUND_EN, 10'h00C without.
REQ-037 cal_abort after 5 samples of a second calibration -> IDLE next cycle, no cal_done, offset_out keeps prior 10'h00C; cal_start during SETTLE has no effect.
REQ-038 rst_n low during ACCUM -> all outputs at reset values immediately; fresh cal_start then completes normally.
REQ-039 sample_valid toggling every third cycle -> exactly 16 accepted samples, cal_done at cycle per REQ-027.

Source files
------------

// File: rtl/adc_cal_pkg.sv
// Shared definitions for the ADC offset calibration controller: FSM encoding,
// offset word width and default parameter values.
package adc_cal_pkg;

  // Width of the raw ADC code and of the two's-complement offset word
  localparam int unsigned OffsetW = 10;

  // Default parameter values for offset_cal_ctrl
  localparam int unsigned         DefNLog2     = 4;
  localparam int unsigned         DefSettleCyc = 8;
  localparam logic [OffsetW-1:0]  DefTarget    = 10'd512;

  // Settle counter width covers SETTLE_CYC up to 255
  localparam int unsigned SettleCntW = 8;

  // Calibration sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAccum,
    StCompute,
    StDone
  } cal_state_e;

endpackage

// File: rtl/cal_accum.sv
// Sample accumulator for offset calibration. Counts accepted samples, sums
// them, and flags the sample that completes the 2^N_LOG2 batch.
module cal_accum
  import adc_cal_pkg::*;
#(
  parameter int unsigned N_LOG2 = DefNLog2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [OffsetW-1:0]        sample_i,
  output logic [OffsetW+N_LOG2:0]   acc_o,
  output logic                      last_o
);

  // One spare bit above the worst-case sum so the adder can never wrap
  localparam int unsigned AccW = OffsetW + N_LOG2 + 1;
  localparam int unsigned CntW = N_LOG2 + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'((1 << N_LOG2) - 1);

  logic [CntW-1:0] count_d, count_q;
  logic [AccW-1:0] acc_d, acc_q;

  // Clear wins over enable; otherwise accept one sample per enabled cycle
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (clr_i) begin
      count_d = '0;
      acc_d   = '0;
    end else if (en_i) begin
      count_d = count_q + CntW'(1);
      acc_d   = acc_q + AccW'(sample_i);
    end
  end

  // Counter and accumulator state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  // Combinational so the sequencer can leave ACCUM on the final sample's edge
  assign last_o = en_i && (count_q == LastIdx);
  assign acc_o  = acc_q;

endmodule

// File: rtl/offset_cal_ctrl.sv
// ADC offset calibration controller. Shorts the ADC input, waits for the
// front end to settle, averages 2^N_LOG2 samples and loads the saturated
// difference TARGET - mean as a two's-complement offset.
// Build option: define OFFSET_CAL_ROUND_EN to round the mean half-up instead
// of truncating it.
module offset_cal_ctrl
  import adc_cal_pkg::*;
#(
  parameter int unsigned         N_LOG2     = DefNLog2,
  parameter int unsigned         SETTLE_CYC = DefSettleCyc,
  parameter logic [OffsetW-1:0]  TARGET     = DefTarget
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cal_start,
  input  logic               cal_abort,
  input  logic               sample_valid,
  input  logic [OffsetW-1:0] sample_data,
  output logic               mux_cal_en,
  output logic               cal_busy,
  output logic               cal_done,
  output logic [OffsetW-1:0] offset_out,
  output logic               offset_valid
);

  localparam int unsigned AccW  = OffsetW + N_LOG2 + 1;
  localparam int unsigned DiffW = AccW + 1;
  localparam logic [SettleCntW-1:0] SettleLast = SettleCntW'(SETTLE_CYC - 1);
  localparam logic signed [DiffW-1:0] SatMax = DiffW'(511);
  localparam logic signed [DiffW-1:0] SatMin = DiffW'(-512);

  cal_state_e               state_d, state_q;
  logic [SettleCntW-1:0]    settle_d, settle_q;
  logic [OffsetW-1:0]       offset_d, offset_q;
  logic                     offset_valid_d, offset_valid_q;
  logic                     cal_done_d, cal_done_q;
  logic                     cal_busy_d, cal_busy_q;
  logic                     mux_cal_en_d, mux_cal_en_q;

  logic                     acc_clr, acc_en, acc_last;
  logic [AccW-1:0]          acc, acc_rnd, mean_full;
  logic signed [DiffW-1:0]  diff;
  logic [OffsetW-1:0]       offset_sat;

  // Abort in IDLE suppresses a simultaneous start
  assign acc_clr = (state_q == StIdle) && cal_start && !cal_abort;
  assign acc_en  = (state_q == StAccum) && sample_valid && !cal_abort;

  cal_accum #(
    .N_LOG2   (N_LOG2)
  ) u_cal_accum (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .sample_i (sample_data),
    .acc_o    (acc),
    .last_o   (acc_last)
  );

`ifdef OFFSET_CAL_ROUND_EN
  localparam logic [AccW-1:0] RoundAdd = AccW'(1) << (N_LOG2 - 1);
  assign acc_rnd = acc + RoundAdd;
`else
  assign acc_rnd = acc;
`endif

  assign mean_full = acc_rnd >> N_LOG2;
  // Both operands zero-extended so the subtraction is exact in signed form
  assign diff = $signed({1'b0, AccW'(TARGET)}) - $signed({1'b0, mean_full});

  // Clamp the correction to the range the offset stage can represent
  always_comb begin
    offset_sat = diff[OffsetW-1:0];
    if (diff > SatMax) begin
      offset_sat = 10'h1FF;
    end else if (diff < SatMin) begin
      offset_sat = 10'h200;
    end
  end

  // Sequencer next state and settle counter
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StIdle: begin
        if (cal_start && !cal_abort) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (cal_abort) begin
          state_d = StIdle;
        end else if (settle_q == SettleLast) begin
          state_d = StAccum;
        end else begin
          settle_d = settle_q + SettleCntW'(1);
        end
      end
      StAccum: begin
        if (cal_abort) begin
          state_d = StIdle;
        end else if (acc_last) begin
          state_d = StCompute;
        end
      end
      StCompute: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    mux_cal_en_d   = (state_d == StSettle) || (state_d == StAccum);
    cal_busy_d     = (state_d != StIdle);
    cal_done_d     = (state_d == StDone);
    offset_d       = offset_q;
    offset_valid_d = offset_valid_q;
    if (state_q == StCompute) begin
      offset_d       = offset_sat;
      offset_valid_d = 1'b1;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      settle_q       <= '0;
      offset_q       <= '0;
      offset_valid_q <= 1'b0;
      cal_done_q     <= 1'b0;
      cal_busy_q     <= 1'b0;
      mux_cal_en_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      offset_q       <= offset_d;
      offset_valid_q <= offset_valid_d;
      cal_done_q     <= cal_done_d;
      cal_busy_q     <= cal_busy_d;
      mux_cal_en_q   <= mux_cal_en_d;
    end
  end

  assign mux_cal_en   = mux_cal_en_q;
  assign cal_busy     = cal_busy_q;
  assign cal_done     = cal_done_q;
  assign offset_out   = offset_q;
  assign offset_valid = offset_valid_q;

endmodule
